tns_enc_22_seq: RTL and testbench
=================================

TNS_ENC_22_SEQ -- requirements
Module: tns_enc_22_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port datain, input, `BLEN08_C bits: unsigned value to encode; width macro from TNS.vh.
REQ-004 SHALL have port in_valid, input, 1 bit: datain is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts datain this cycle.
REQ-006 SHALL have port codeout, output, 22 bits: TNS codeword; bit 21 has weight `TNS08_C, bits 20..0 have weights `TNS07_A down to `TNS01_C, in the same order the 22-bit TNS decoder uses.
REQ-007 SHALL have port out_valid, output, 1 bit: codeout and out_err are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream consumer accepts codeout.
REQ-009 SHALL have port out_err, output, 1 bit: datain was not representable.

Function
REQ-010 SHALL perform greedy MSB-first encoding: remainder R = datain; for bit i = 21 down to 0, set code[i] = (R >= W[i]) and subtract W[i] from R when set; W[i] are the TNS.vh weight macros.
REQ-011 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-012 IDLE: in_ready = 1, out_valid = 0; on in_valid, SHALL latch datain into R, clear the code register, load bit index 21, and go to CALC.
REQ-013 CALC: in_ready = 0, out_valid = 0; SHALL resolve one bit per cycle, decrementing the index; after bit 0 resolves, SHALL go to DONE.
REQ-014 On entry to DONE, SHALL set out_err = 1 iff the final R is non-zero; the codeword still holds the greedy result.
REQ-015 DONE: out_valid = 1, in_ready = 0; codeout and out_err SHALL hold stable until out_valid and out_ready are both high, then the FSM SHALL return to IDLE.
REQ-016 Latency: handshake in cycle N SHALL give out_valid in cycle N+23 (1 load cycle plus 22 CALC cycles, registered output); throughput is one word per 24 cycles minimum.
REQ-017 There is no bypass from DONE to accept a new input; in_valid outside IDLE SHALL be ignored.
REQ-018 Remainder and compare arithmetic SHALL be `BLEN08_C bits wide, unsigned, and no subtraction SHALL underflow.
REQ-019 For any datain not flagged by out_err, the 22-bit TNS decoder applied to codeout SHALL return datain exactly.

Reset
REQ-020 rst SHALL force IDLE, codeout = 0, out_valid = 0, out_err = 0, R = 0, index = 0, and in_ready = 1 in the cycle after reset deasserts.
REQ-021 rst asserted in CALC or DONE SHALL abort the word with no output produced; rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-022 Macro TNS_ENC_DUAL_STEP_EN defined: CALC SHALL resolve two bits per cycle (i and i-1, chained combinationally), 11 CALC cycles, latency N+12.
REQ-023 Macro TNS_ENC_DUAL_STEP_EN undefined: CALC SHALL resolve one bit per cycle as in REQ-013; codeout and out_err SHALL be bit-identical in both builds.

Verification
REQ-024 Reset then datain = 0, in_valid for 1 cycle -> codeout = 22'h000000, out_err = 0, out_valid exactly 23 cycles after handshake.
REQ-025 datain = `TNS01_C -> codeout = 22'h000001; datain = `TNS08_C -> codeout = 22'h200000; out_err = 0 in both cases.
REQ-026 datain = sum of all 22 weights -> codeout = 22'h3FFFFF, out_err = 0; datain = sum + 1 (if it fits in `BLEN08_C bits) -> out_err = 1.
REQ-027 Hold out_ready = 0 for 10 cycles in DONE -> codeout stable, in_ready = 0, in_valid ignored; release -> IDLE the next cycle.
REQ-028 Assert rst in CALC cycle 5 -> no out_valid; all outputs equal reset values; next word encodes correctly.
REQ-029 Random sweep of 10,000 in-range values through encoder then 22-bit decoder -> decoded output equals datain; repeat with TNS_ENC_DUAL_STEP_EN defined and check latency is 12 cycles.

Source files
------------

// File: rtl/tns_enc_22_seq.sv
// ---------------------------------------------------------------------------
// tns_enc_22_seq
//
// Sequential greedy encoder from an unsigned binary value into a 22-bit TNS
// codeword. Walks the codeword MSB first. At each position it sets the bit
// when the remainder is at least that position's weight, and then subtracts
// the weight. A non-zero final remainder means the value cannot be
// represented; the bit pattern is still the greedy result.
//
// Ports
//   clk        : clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   datain     : value to encode (`BLEN08_C bits, unsigned)
//   in_valid   : datain is valid this cycle
//   in_ready   : high only in IDLE; a word is accepted on in_valid && in_ready
//   codeout    : codeword; bit 21 = `TNS08_C, bits 20..0 = `TNS07_A .. `TNS01_C
//   out_valid  : codeout / out_err hold a finished word (DONE state)
//   out_ready  : consumer takes the finished word
//   out_err    : final remainder was non-zero (value not representable)
//
// Weights and width normally come from TNS.vh. The defaults below are used
// only when those macros are not already defined. They form a Fibonacci
// ladder, so every value from 0 up to the sum of all weights has a greedy
// encoding.
//
// Build option
//   TNS_ENC_DUAL_STEP_EN : when defined, CALC resolves two bits per cycle
//                          (11 CALC cycles, latency N+12). When undefined,
//                          CALC resolves one bit per cycle (22 CALC cycles,
//                          latency N+23). The codewords are identical in
//                          both builds.
// ---------------------------------------------------------------------------

`ifndef BLEN08_C
`define BLEN08_C 17
`endif

`ifndef TNS01_C
`define TNS01_C 1
`define TNS01_B 2
`define TNS01_A 3
`define TNS02_C 5
`define TNS02_B 8
`define TNS02_A 13
`define TNS03_C 21
`define TNS03_B 34
`define TNS03_A 55
`define TNS04_C 89
`define TNS04_B 144
`define TNS04_A 233
`define TNS05_C 377
`define TNS05_B 610
`define TNS05_A 987
`define TNS06_C 1597
`define TNS06_B 2584
`define TNS06_A 4181
`define TNS07_C 6765
`define TNS07_B 10946
`define TNS07_A 17711
`define TNS08_C 28657
`endif

module tns_enc_22_seq (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [`BLEN08_C-1:0] datain,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [21:0]          codeout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_err
);

  localparam int BLEN  = `BLEN08_C;
  localparam int NBITS = 22;

  typedef logic [BLEN-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Element i is the weight of codeword bit i (element 0 is the LSB).
  localparam word_t WEIGHT [NBITS] = '{
    word_t'(`TNS01_C), word_t'(`TNS01_B), word_t'(`TNS01_A),
    word_t'(`TNS02_C), word_t'(`TNS02_B), word_t'(`TNS02_A),
    word_t'(`TNS03_C), word_t'(`TNS03_B), word_t'(`TNS03_A),
    word_t'(`TNS04_C), word_t'(`TNS04_B), word_t'(`TNS04_A),
    word_t'(`TNS05_C), word_t'(`TNS05_B), word_t'(`TNS05_A),
    word_t'(`TNS06_C), word_t'(`TNS06_B), word_t'(`TNS06_A),
    word_t'(`TNS07_C), word_t'(`TNS07_B), word_t'(`TNS07_A),
    word_t'(`TNS08_C)
  };

  state_t           state_reg, state_next;
  word_t            rem_reg,   rem_next;
  logic [NBITS-1:0] code_reg,  code_next;
  logic [4:0]       idx_reg,   idx_next;
  logic             err_reg,   err_next;

  // ---------------------------------------------------------------------
  // Bit resolution for the current index
  // ---------------------------------------------------------------------
  word_t            w_hi;
  word_t            rem_hi;
  logic             ge_hi;
  logic [NBITS-1:0] hit_hi;

  word_t            rem_step;   // remainder after this cycle's bit(s)
  logic [NBITS-1:0] set_mask;   // codeword bits set this cycle
  logic             last_step;  // this cycle resolves bit 0
  logic [4:0]       idx_step;   // index for the next CALC cycle

  assign w_hi   = WEIGHT[idx_reg];
  assign ge_hi  = (rem_reg >= w_hi);
  // The subtraction happens only when rem_reg >= w_hi, so it cannot underflow.
  assign rem_hi = ge_hi ? (rem_reg - w_hi) : rem_reg;

  // One-hot decode of the index, used to place the resolved bit.
  for (genvar gi = 0; gi < NBITS; gi++) begin : gen_hit_hi
    assign hit_hi[gi] = (idx_reg == 5'(gi));
  end

`ifdef TNS_ENC_DUAL_STEP_EN
  // The second bit (idx-1) starts from the remainder left by the first bit.
  // The two compare/subtract stages are chained combinationally in one cycle.
  logic [4:0]       idx_lo;
  word_t            w_lo;
  word_t            rem_lo;
  logic             ge_lo;
  logic [NBITS-1:0] hit_lo;

  // The clamp keeps the table lookup in range while idle (idx_reg == 0).
  assign idx_lo = (idx_reg == 5'd0) ? 5'd0 : (idx_reg - 5'd1);
  assign w_lo   = WEIGHT[idx_lo];
  assign ge_lo  = (rem_hi >= w_lo);
  assign rem_lo = ge_lo ? (rem_hi - w_lo) : rem_hi;

  for (genvar gi = 0; gi < NBITS; gi++) begin : gen_hit_lo
    assign hit_lo[gi] = (idx_lo == 5'(gi));
  end

  // Index steps 21, 19, ..., 1; the pair (1, 0) is the final one.
  assign set_mask  = (hit_hi & {NBITS{ge_hi}}) | (hit_lo & {NBITS{ge_lo}});
  assign rem_step  = rem_lo;
  assign last_step = (idx_reg == 5'd1);
  assign idx_step  = idx_reg - 5'd2;
`else
  assign set_mask  = hit_hi & {NBITS{ge_hi}};
  assign rem_step  = rem_hi;
  assign last_step = (idx_reg == 5'd0);
  assign idx_step  = idx_reg - 5'd1;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: if (in_valid)  state_next = S_CALC;
      S_CALC: if (last_step) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (decoded from the registered state only)
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_reg)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: remainder, codeword, index, error flag
  // ---------------------------------------------------------------------
  always_comb begin
    rem_next  = rem_reg;
    code_next = code_reg;
    idx_next  = idx_reg;
    err_next  = err_reg;
    if ((state_reg == S_IDLE) && in_valid) begin
      rem_next  = datain;
      code_next = '0;
      idx_next  = 5'd21;
      err_next  = 1'b0;
    end else if (state_reg == S_CALC) begin
      rem_next  = rem_step;
      code_next = code_reg | set_mask;
      if (last_step) begin
        idx_next = 5'd0;
        // The flag is captured once, on entry to DONE.
        err_next = (rem_step != '0);
      end else begin
        idx_next = idx_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      code_reg <= '0;
      idx_reg  <= 5'd0;
      err_reg  <= 1'b0;
    end else begin
      rem_reg  <= rem_next;
      code_reg <= code_next;
      idx_reg  <= idx_next;
      err_reg  <= err_next;
    end
  end

  assign codeout = code_reg;
  assign out_err = err_reg;

endmodule

// File: tb/tb_tns_enc_22_seq.sv
// ---------------------------------------------------------------------------
// tb_tns_enc_22_seq
//
// Directed and swept stimulus for tns_enc_22_seq. A reference model runs
// alongside the encoder. It consists of:
//   - a greedy encoder and a weight-sum decoder written as plain arithmetic
//     over the weight table;
//   - a busy/latency tracker that predicts in_ready, out_valid and the
//     finished word for every cycle.
// Literal codewords for the directed words pin both the model and the design.
// ---------------------------------------------------------------------------

`ifndef BLEN08_C
`define BLEN08_C 17
`endif

`ifndef TNS01_C
`define TNS01_C 1
`define TNS01_B 2
`define TNS01_A 3
`define TNS02_C 5
`define TNS02_B 8
`define TNS02_A 13
`define TNS03_C 21
`define TNS03_B 34
`define TNS03_A 55
`define TNS04_C 89
`define TNS04_B 144
`define TNS04_A 233
`define TNS05_C 377
`define TNS05_B 610
`define TNS05_A 987
`define TNS06_C 1597
`define TNS06_B 2584
`define TNS06_A 4181
`define TNS07_C 6765
`define TNS07_B 10946
`define TNS07_A 17711
`define TNS08_C 28657
`endif

module tb_tns_enc_22_seq;

  localparam int BLEN = `BLEN08_C;
`ifdef TNS_ENC_DUAL_STEP_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 23;
`endif

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [BLEN-1:0] datain    = '0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [21:0]     codeout;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_err;

  always #5 clk = ~clk;

  tns_enc_22_seq dut (
    .clk       (clk),
    .rst       (rst),
    .datain    (datain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeout   (codeout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  // Weight of codeword bit i.
  int unsigned wt [22] = '{
    `TNS01_C, `TNS01_B, `TNS01_A, `TNS02_C, `TNS02_B, `TNS02_A,
    `TNS03_C, `TNS03_B, `TNS03_A, `TNS04_C, `TNS04_B, `TNS04_A,
    `TNS05_C, `TNS05_B, `TNS05_A, `TNS06_C, `TNS06_B, `TNS06_A,
    `TNS07_C, `TNS07_B, `TNS07_A, `TNS08_C
  };

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Greedy reference encoder.
  function automatic void model_enc(input int unsigned d, output logic [21:0] c, output logic e);
    int unsigned r;
    r = d;
    c = '0;
    for (int i = 21; i >= 0; i--) begin
      if (r >= wt[i]) begin
        c[i] = 1'b1;
        r    = r - wt[i];
      end
    end
    e = (r != 0);
  endfunction

  // 22-bit TNS decoder: the sum of the weights of the set bits.
  function automatic int unsigned model_dec(input logic [21:0] c);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 22; i++) if (c[i]) s += wt[i];
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Every-cycle compare against the model, sampled on the falling edge.
  // After comparing, the model predicts what the next rising edge does.
  // ---------------------------------------------------------------------
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  int          m_hs   = 0;
  int unsigned m_data = 0;
  logic [21:0] m_code = '0;
  logic        m_err  = 1'b0;

  always @(negedge clk) begin
    bit exp_v;
    exp_v = m_busy && ((cyc - m_hs) >= LAT);
    if (m_live) begin
      chk("cyc_in_ready", in_ready, !m_busy);
      chk("cyc_out_valid", out_valid, exp_v);
      if (exp_v) begin
        chk("cyc_codeout", codeout, m_code);
        chk("cyc_out_err", out_err, m_err);
        if (!m_err) chk("cyc_decode", model_dec(codeout), m_data);
      end
    end
    if (rst) begin
      m_busy = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (!m_busy && in_valid) begin
        m_busy = 1'b1;
        m_hs   = cyc;
        m_data = int'(datain);
        model_enc(m_data, m_code, m_err);
      end else if (exp_v && out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // One word: handshake, bounded wait, optional literal check, optional
  // hold in DONE with in_valid toggled, then release.
  // ---------------------------------------------------------------------
  task automatic run_word(input string name, input int unsigned d, input int hold,
                          input bit use_lit, input logic [21:0] exp_c, input logic exp_e);
    int          hs;
    logic [21:0] held;
    chk({name, "_ready"}, in_ready, 1'b1);
    datain   = BLEN'(d);
    in_valid = 1'b1;
    hs       = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < LAT + 10 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_latency"}, cyc - hs, LAT);
    if (use_lit) begin
      chk({name, "_code"}, codeout, exp_c);
      chk({name, "_err"}, out_err, exp_e);
    end
    held = codeout;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      datain   = BLEN'($urandom);
      chk({name, "_hold_ready"}, in_ready, 1'b0);
      @(posedge clk); #1;
      chk({name, "_hold_code"}, codeout, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_idle"}, {in_ready, out_valid}, 2'b10);
    $display("word %s: datain=%0d codeout=0x%06h out_err=%0b", name, d, held, out_err);
  endtask

  // Directed vectors with hand-computed codewords (Fibonacci weights).
  int unsigned dv [9] = '{0, 1, 28657, 75023, 75024, 4, 12, 100, 131071};
  logic [21:0] dc [9] = '{22'h000000, 22'h000001, 22'h200000, 22'h3FFFFF,
                          22'h3FFFFF, 22'h000005, 22'h000015, 22'h000214,
                          22'h3FFFFF};
  logic        de [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int unsigned sumw;
    bit          seen;
    int unsigned d;

    sumw = 0;
    for (int i = 0; i < 22; i++) sumw += wt[i];

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", {in_ready, out_valid, out_err, codeout}, {1'b1, 1'b0, 1'b0, 22'h0});

    for (int i = 0; i < 9; i++) begin
      run_word($sformatf("dir%0d", i), dv[i], (i == 2) ? 10 : 0, 1'b1, dc[i], de[i]);
    end

    // Abort a word in CALC cycle 5.
    datain   = BLEN'(500);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_outputs", {in_ready, out_valid, out_err, codeout}, {1'b1, 1'b0, 1'b0, 22'h0});
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    chk("abort_no_valid", seen, 1'b0);
    $display("word abort: datain=500 reset in CALC cycle 5, out_valid seen=%0b", seen);
    run_word("after_abort", 100, 0, 1'b1, 22'h000214, 1'b0);

    // Swept words, checked by the every-cycle model.
    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 9) d = $urandom_range((1 << BLEN) - 1, sumw + 1);
      else             d = $urandom_range(sumw, 0);
      run_word($sformatf("sweep%0d", i), d, 0, 1'b0, 22'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
